bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 19 +
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W   : bits per BCD digit
//   BCD_NINE      : saturation digit value
//   state_t       : converter FSM states
//   bcd_max_value : 10^digits - 1, largest value representable in 'digits' BCD digits
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] bcd_max_value(input int unsigned digits);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
//   digit : BCD digit before correction
//   fixed : corrected digit (4-bit add, no carry out)
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] fixed
);

  always_comb begin
    fixed = digit;
    if (digit >= 4'd5) begin
      fixed = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A request is accepted in IDLE or in the DONE cycle; the result and overflow
// flag update only on the done edge and hold through the next conversion.
//   clk, reset : clock, asynchronous active-high reset
//   start, bin : conversion request and binary operand (sampled on accept)
//   busy       : conversion in progress
//   done       : one-cycle pulse, bcd/ovf updated at the same edge
//   ovf        : last accepted bin exceeded 10^DIGITS-1 (bcd saturated to 9s)
//   bcd        : packed result, digit i at [4i+3:4i], digit 0 least significant
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned W      = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [W-1:0]                    bin,
  output logic                            busy,
  output logic                            done,
  output logic                            ovf,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd
);

  localparam int unsigned BW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [63:0]   MAX_VALUE = bcd_max_value(DIGITS);
  localparam logic [CW-1:0] CNT_INIT  = CW'(W);

  state_t          state, state_next;
  logic [W-1:0]    shift;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adjusted;
  logic [BW-1:0]   scratch_shifted;
  logic [CW-1:0]   count;
  logic            ovf_pending;
  logic            accept;
  logic            last_shift;
  logic [63:0]     bin_ext;

  assign bin_ext = 64'(bin);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .fixed (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct first, then shift; the top bit of the corrected scratch is dropped
  // (only matters on overflow, where the result is saturated anyway).
  assign scratch_shifted = {adjusted[BW-2:0], shift[W-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_shift = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == CW'(1)) begin
          last_shift = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift       <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      bcd         <= '0;
      ovf         <= 1'b0;
    end else if (accept) begin
      shift       <= bin;
      scratch     <= '0;
      count       <= CNT_INIT;
      ovf_pending <= (bin_ext > MAX_VALUE);
    end else if (state == SHIFT) begin
      scratch <= scratch_shifted;
      shift   <= shift << 1;
      count   <= count - CW'(1);
      if (last_shift) begin
        bcd <= ovf_pending ? {DIGITS{BCD_NINE}} : scratch_shifted;
        ovf <= ovf_pending;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: expected results are queued when a
// request is accepted and compared when done pulses.
module tb_bin2bcd_seq;

  localparam int unsigned W      = 14;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned LIMIT  = 40;

  logic        clk;
  logic        reset;
  logic        start;
  logic [W-1:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd;

  int unsigned vectors;
  int unsigned miscompares;

  logic [16:0] exp_q[$];
  logic [15:0] last_bcd;
  logic        last_ovf;
  logic        prev_done;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal reference: {ovf, bcd}
  function automatic logic [16:0] model(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    if (v > 9999) return {1'b1, 16'h9999};
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [16:0] e;
    if (reset) begin
      prev_done <= 1'b0;
    end else begin
      if (done) begin
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("done_width", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("bcd", {16'd0, bcd}, {16'd0, e[15:0]});
          check("ovf", {31'd0, ovf}, {31'd0, e[16]});
          last_bcd = e[15:0];
          last_ovf = e[16];
        end
      end else if (busy) begin
        check("bcd_hold", {16'd0, bcd}, {16'd0, last_bcd});
        check("ovf_hold", {31'd0, ovf}, {31'd0, last_ovf});
      end
      prev_done <= done;
    end
  end

  // One request; optionally pulse a start mid-conversion that must be ignored.
  task automatic run(input int unsigned v, input bit pulse);
    int unsigned n;
    @(negedge clk);
    start = 1'b1;
    bin   = W'(v);
    exp_q.push_back(model(v));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = W'($urandom);
    n = 0;
    while (!done && n < LIMIT) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pulse && n == 5) begin
        start = 1'b1;
        bin   = W'(777);
      end else if (pulse && n == 6) begin
        start = 1'b0;
      end
    end
    check("latency", n, W);
  endtask

  initial begin
    int unsigned n;
    vectors     = 0;
    miscompares = 0;
    last_bcd    = '0;
    last_ovf    = 1'b0;
    prev_done   = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_bcd",  {16'd0, bcd},  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // basic, boundaries, overflow
    run(1234, 1'b0);
    run(0, 1'b0);
    run(9999, 1'b0);
    run(10000, 1'b0);
    run(16383, 1'b0);
    run(42, 1'b0);

    // start held: bin changes mid-conversion, back-to-back accept in DONE cycle
    @(negedge clk);
    start = 1'b1;
    bin   = W'(57);
    exp_q.push_back(model(57));
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!done && n < LIMIT) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 5) bin = W'(999);
    end
    check("latency_held", n, W);
    exp_q.push_back(model(999));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < LIMIT) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency_b2b", n, W);

    // start pulsed mid-SHIFT must not launch anything
    run(321, 1'b1);
    repeat (25) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    // async reset in SHIFT cycle 7 of a conversion
    run(42, 1'b0);
    @(negedge clk);
    start = 1'b1;
    bin   = W'(4321);
    exp_q.push_back(model(4321));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_ovf",  {31'd0, ovf},  32'd0);
    check("arst_bcd",  {16'd0, bcd},  32'd0);
    exp_q.delete();
    last_bcd = '0;
    last_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run(8, 1'b0);

    // random sweep
    for (int i = 0; i < 2000; i++) begin
      run($urandom_range(16383, 0), 1'b0);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
